// File: rtl/ssp_uart_ctrl_pkg.sv
// Shared types and widths for the SSP UART bus master and its arbiter.
package ssp_uart_ctrl_pkg;

  localparam int SSP_AW = 3;
  localparam int SSP_DW = 12;
  localparam int NREQ   = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EN,
    EOC,
    GAP
  } state_t;

  typedef struct packed {
    logic [SSP_AW-1:0] ra;
    logic              wnr;
    logic [SSP_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ssp_uart_rr_arb.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module ssp_uart_rr_arb (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  // last resets to 1 so that requester 0 wins the first tie.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/ssp_uart_ctrl.sv
// SSP bus master: arbitrates two requesters and runs each register access
// through a fixed-timing SETUP/EN/EOC/GAP sequence on the SSP UART port.
module ssp_uart_ctrl
  import ssp_uart_ctrl_pkg::*;
#(
  parameter int EN_CYCLES  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*SSP_AW-1:0]   req_ra,
  input  logic [NREQ-1:0]          req_wnr,
  input  logic [NREQ*SSP_DW-1:0]   req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_id,
  output logic [SSP_DW-1:0]        rsp_rdata,
  output logic                     busy,
  output logic                     SSP_SSEL,
  output logic [SSP_AW-1:0]        SSP_RA,
  output logic                     SSP_WnR,
  output logic                     SSP_En,
  output logic                     SSP_EOC,
  output logic [SSP_DW-1:0]        SSP_DI,
  input  logic [SSP_DW-1:0]        SSP_DO
);

  localparam logic [3:0] EN_LOAD  = 4'(EN_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] cnt;
  req_t       lat;
  logic       lat_id;
  logic [1:0] gnt;
  logic       accept;
  req_t       win_req;
  logic       win_id;
  logic       active;

  ssp_uart_rr_arb u_arb (
    .Clk     (Clk),
    .Rst     (Rst),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  // Grant is only exposed in IDLE and never while reset is held.
  assign req_ready = (Rst && state == IDLE) ? gnt : '0;
  assign accept    = |req_ready;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    win_req = '0;
    win_id  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_req.ra    = req_ra[i*SSP_AW +: SSP_AW];
        win_req.wnr   = req_wnr[i];
        win_req.wdata = req_wdata[i*SSP_DW +: SSP_DW];
        win_id        = 1'(i);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = EN;
      EN:      if (cnt == 4'd0) state_next = EOC;
      EOC:     state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (cnt == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // in this block sees pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat       <= '0;
      lat_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat    <= win_req;
            lat_id <= win_id;
          end
        end
        SETUP: cnt <= EN_LOAD;
        EN, GAP: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        EOC: begin
          // DO is captured at the end of EOC; the pulse lands in the next cycle.
          cnt       <= GAP_LOAD;
          rsp_valid <= 1'b1;
          rsp_id    <= lat_id;
          rsp_rdata <= lat.wnr ? '0 : SSP_DO;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign active   = (state == SETUP) || (state == EN) || (state == EOC);
  assign busy     = (state != IDLE);
  assign SSP_SSEL = active;
  assign SSP_En   = (state == EN);
  assign SSP_EOC  = (state == EOC);
  assign SSP_RA   = active ? lat.ra    : '0;
  assign SSP_WnR  = active ? lat.wnr   : 1'b0;
  assign SSP_DI   = active ? lat.wdata : '0;

endmodule

// File: tb/tb_ssp_uart_ctrl.sv
// Directed bench: reset, write, read, fairness, abort and zero-gap timing
// against hand-computed cycle expectations (EN_CYCLES=2).
module tb_ssp_uart_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;

  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [5:0]  req_ra = '0;
  logic [1:0]  req_wnr = '0;
  logic [23:0] req_wdata = '0;
  logic        rsp_valid, rsp_id, busy;
  logic [11:0] rsp_rdata;
  logic        SSP_SSEL, SSP_WnR, SSP_En, SSP_EOC;
  logic [2:0]  SSP_RA;
  logic [11:0] SSP_DI;
  logic [11:0] SSP_DO = 12'hFFF;

  logic [1:0]  z_valid = '0;
  logic [1:0]  z_ready;
  logic [5:0]  z_ra = '0;
  logic [1:0]  z_wnr = '0;
  logic [23:0] z_wdata = '0;
  logic        z_rsp_valid, z_rsp_id, z_busy;
  logic [11:0] z_rsp_rdata;
  logic        z_sel, z_wnr_o, z_en, z_eoc;
  logic [2:0]  z_ra_o;
  logic [11:0] z_di;
  logic [11:0] z_do = '0;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  ssp_uart_ctrl #(.EN_CYCLES(2), .GAP_CYCLES(1)) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ra(req_ra),
    .req_wnr(req_wnr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .busy(busy),
    .SSP_SSEL(SSP_SSEL), .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR), .SSP_En(SSP_En),
    .SSP_EOC(SSP_EOC), .SSP_DI(SSP_DI), .SSP_DO(SSP_DO)
  );

  ssp_uart_ctrl #(.EN_CYCLES(2), .GAP_CYCLES(0)) dut_z (
    .Clk(Clk), .Rst(Rst),
    .req_valid(z_valid), .req_ready(z_ready), .req_ra(z_ra),
    .req_wnr(z_wnr), .req_wdata(z_wdata),
    .rsp_valid(z_rsp_valid), .rsp_id(z_rsp_id), .rsp_rdata(z_rsp_rdata), .busy(z_busy),
    .SSP_SSEL(z_sel), .SSP_RA(z_ra_o), .SSP_WnR(z_wnr_o), .SSP_En(z_en),
    .SSP_EOC(z_eoc), .SSP_DI(z_di), .SSP_DO(z_do)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive point is 1 time unit after the rising edge; sampling 1 unit later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ids[4];
    int cyc[4];
    int seen;

    // ---------------- reset ----------------
    Rst = 1'b0;
    req_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      tick();
      settle();
      check("rst_ready", req_ready, 2'b00);
      check("rst_ssel", SSP_SSEL, 0);
      check("rst_en_eoc", {SSP_En, SSP_EOC}, 2'b00);
      check("rst_ra_di", {SSP_RA, SSP_DI, SSP_WnR}, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
    end
    tick();
    Rst = 1'b1;
    settle();
    check("rst_first_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    tick();
    settle();
    check("drop_valid_idle", busy, 0);

    // ---------------- write, requester 0 ----------------
    req_valid = 2'b01;
    req_wnr   = 2'b01;
    req_ra    = {3'd0, 3'd2};
    req_wdata = {12'h000, 12'hA5C};
    settle();
    check("wr_ready_c0", req_ready, 2'b01);
    for (int c = 1; c <= 6; c++) begin
      tick();
      req_valid = 2'b00;
      settle();
      check($sformatf("wr_ssel_c%0d", c), SSP_SSEL, (c >= 1 && c <= 4));
      check($sformatf("wr_en_c%0d", c), SSP_En, (c == 2 || c == 3));
      check($sformatf("wr_eoc_c%0d", c), SSP_EOC, (c == 4));
      check($sformatf("wr_rspv_c%0d", c), rsp_valid, (c == 5));
      if (c <= 4) begin
        check($sformatf("wr_di_c%0d", c), SSP_DI, 12'hA5C);
        check($sformatf("wr_ra_c%0d", c), SSP_RA, 3'd2);
        check($sformatf("wr_wnr_c%0d", c), SSP_WnR, 1);
      end
      if (c == 5) begin
        check("wr_rsp_id", rsp_id, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_gap_di", SSP_DI, 0);
        check("wr_gap_busy", busy, 1);
      end
      if (c == 6) check("wr_idle_busy", busy, 0);
    end

    // ---------------- read, requester 1 ----------------
    req_valid = 2'b10;
    req_wnr   = 2'b00;
    req_ra    = {3'd5, 3'd0};
    req_wdata = {12'h777, 12'h000};
    settle();
    check("rd_ready_c0", req_ready, 2'b10);
    for (int c = 1; c <= 6; c++) begin
      tick();
      req_valid = 2'b00;
      SSP_DO = (c == 4) ? 12'h3F0 : 12'hFFF;
      settle();
      if (c == 1) begin
        check("rd_ra", SSP_RA, 3'd5);
        check("rd_wnr", SSP_WnR, 0);
      end
      if (c == 4) check("rd_eoc", SSP_EOC, 1);
      check($sformatf("rd_rspv_c%0d", c), rsp_valid, (c == 5));
      if (c == 5) begin
        check("rd_rsp_id", rsp_id, 1);
        check("rd_rsp_rdata", rsp_rdata, 12'h3F0);
      end
      if (c == 6) begin
        check("rd_hold_id", rsp_id, 1);
        check("rd_hold_rdata", rsp_rdata, 12'h3F0);
      end
    end

    // ---------------- fairness ----------------
    req_valid = 2'b11;
    req_wnr   = 2'b11;
    req_ra    = {3'd6, 3'd1};
    req_wdata = {12'h111, 12'h222};
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      settle();
      if (req_ready != 2'b00) begin
        ids[n] = int'(req_ready[1]);
        cyc[n] = c;
        n++;
      end
      tick();
    end
    req_valid = 2'b00;
    check("fair_count", n, 4);
    for (int i = 0; i < n; i++) begin
      check($sformatf("fair_id%0d", i), ids[i], i % 2);
      if (i > 0) check($sformatf("fair_gap%0d", i), cyc[i] - cyc[i-1], 6);
    end
    for (int c = 0; c < 8; c++) tick();
    check("fair_done_busy", busy, 0);

    // ---------------- abort ----------------
    req_valid = 2'b01;
    req_wnr   = 2'b00;
    req_ra    = {3'd0, 3'd3};
    settle();
    check("ab_ready_c0", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    settle();
    check("ab_en2", SSP_En, 1);
    Rst = 1'b0;
    tick();
    settle();
    check("ab_ssel", SSP_SSEL, 0);
    check("ab_en", SSP_En, 0);
    check("ab_busy", busy, 0);
    Rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) seen++;
      tick();
    end
    check("ab_no_rsp", seen, 0);

    // ---------------- zero gap ----------------
    z_valid = 2'b01;
    z_wnr   = 2'b01;
    z_ra    = {3'd0, 3'd1};
    z_wdata = {12'h000, 12'h123};
    settle();
    check("zg_ready_c0", z_ready, 2'b01);
    for (int c = 1; c <= 6; c++) begin
      tick();
      settle();
      check($sformatf("zg_ssel_c%0d", c), z_sel, (c != 5));
      if (c == 5) begin
        check("zg_rspv", z_rsp_valid, 1);
        check("zg_ready_coincide", z_ready, 2'b01);
      end
      if (c == 6) begin
        check("zg_rspv_off", z_rsp_valid, 0);
        z_valid = 2'b00;
      end
    end
    for (int c = 0; c < 8; c++) tick();
    check("zg_done_busy", z_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssp_uart_ctrl.md
Name: ssp_uart_ctrl

Overview:
- Two-port SSP bus master that sequences register accesses into the SSP UART slave port (SSP_SSEL, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI, SSP_DO).
- Arbitrates round-robin between two requesters, e.g. the host CPU path and the IRQ service engine.
- Runs each access through a fixed-timing state machine and returns read data with a requester tag.
- Sits between the system interconnect and the SSP UART core, in the SSP clock domain.

Parameters:
- EN_CYCLES, 2, cycles SSP_En is held high per access; legal range 1..15.
- GAP_CYCLES, 1, idle cycles with SSP_SSEL low between accesses; legal range 0..15.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous, active-low reset.
- req_valid  in  2  per-requester access request; bit i belongs to requester i.
- req_ready  out  2  per-requester accept strobe; one-hot or zero.
- req_ra  in  2x3  register address, requester i uses slice [3i+2:3i].
- req_wnr  in  2  1 = write, 0 = read, per requester.
- req_wdata  in  2x12  write data, requester i uses slice [12i+11:12i].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_id  out  1  requester index of the completed access.
- rsp_rdata  out  12  read data; 0 for writes.
- busy  out  1  high in every state except IDLE.
- SSP_SSEL  out  1  slave select, active high.
- SSP_RA  out  3  register address to the SSP UART.
- SSP_WnR  out  1  access direction to the SSP UART.
- SSP_En  out  1  data transfer phase strobe.
- SSP_EOC  out  1  end-of-cycle strobe.
- SSP_DI  out  12  write data to the SSP UART.
- SSP_DO  in  12  read data from the SSP UART.

Behaviour:
- Reset (Rst=0 at a Clk edge):
  - state=IDLE; RR pointer selects requester 0 first.
  - All outputs 0; req_ready forced to 0 while Rst=0.
  - Reset mid-access aborts the access: no rsp_valid, and SSP_SSEL drops on the next cycle.
- States: IDLE -> SETUP -> EN -> EOC -> GAP -> IDLE. When GAP_CYCLES=0, EOC goes straight to IDLE.
- IDLE:
  - req_ready[w] is combinational, equal to 1 for winner w whenever any req_valid is set.
  - Acceptance is valid & ready in the same cycle (cycle 0).
  - On acceptance, latch ra, wnr, wdata and id=w, then go to SETUP.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - The pointer updates on acceptance only.
  - A requester may drop valid before acceptance without penalty.
- SETUP (cycle 1): SSP_SSEL=1; SSP_RA, SSP_WnR and SSP_DI carry the latched values, which stay stable until EOC ends.
- EN (cycles 2..1+EN_CYCLES):
  - SSP_SSEL=1 and SSP_En=1.
  - A 4-bit down-counter loaded with EN_CYCLES-1 on entry; exit when it reaches 0.
- EOC (cycle 2+EN_CYCLES):
  - SSP_SSEL=1 and SSP_EOC=1.
  - For a read, SSP_DO is sampled at the end of this cycle.
- Response (cycle 3+EN_CYCLES):
  - rsp_valid=1 for exactly one cycle, with rsp_id=latched id and rsp_rdata = sampled DO for reads, 0 for writes.
  - rsp_id and rsp_rdata hold their values until the next response.
  - There is no backpressure on the response.
- GAP:
  - SSP_SSEL=0, SSP_En=0, SSP_EOC=0; SSP_RA, SSP_WnR and SSP_DI are driven to 0.
  - Lasts GAP_CYCLES cycles (counter reuse), then IDLE.
  - rsp_valid fires in the first GAP cycle.
- Back-to-back:
  - The earliest next acceptance is cycle 3+EN_CYCLES+GAP_CYCLES.
  - With GAP_CYCLES=0 this is the response cycle itself, so rsp_valid and a new acceptance may coincide.
- SSP_En and SSP_EOC are never high together. SSP_SSEL is low in IDLE and GAP.
- busy=1 from SETUP through the end of GAP.

Decomposition:
- ssp_uart_ctrl_pkg holds:
  - state_t enum {IDLE, SETUP, EN, EOC, GAP}
  - localparams SSP_AW=3, SSP_DW=12, NREQ=2
  - a req_t struct {ra, wnr, wdata}
- Sub-module ssp_uart_rr_arb: 2-way round-robin arbiter.
  - Inputs: Clk, Rst, req[1:0], advance.
  - Output: one-hot gnt[1:0].
  - Pointer state lives inside the arbiter.

Test Plan:
- Reset: hold Rst=0 for 3 cycles with req_valid=2'b11 -> req_ready=0, all SSP outputs 0, rsp_valid=0; after release requester 0 is granted first.
- Write: EN_CYCLES=2, GAP_CYCLES=1; requester 0 writes RA=3'd2, wdata=12'hA5C accepted at cycle 0.
  - SSP_SSEL high cycles 1-4; SSP_En high cycles 2-3; SSP_EOC high cycle 4.
  - SSP_DI=12'hA5C and SSP_RA=2 through cycles 1-4.
  - rsp_valid at cycle 5 with rsp_id=0, rsp_rdata=0.
- Read: requester 1 reads RA=3'd5; the slave drives SSP_DO=12'h3F0 during EOC -> rsp_valid with rsp_id=1, rsp_rdata=12'h3F0.
- Fairness: both requesters held valid for 4 accesses -> grants ordered 0,1,0,1; each next acceptance lands exactly 6 cycles after the previous one (EN=2, GAP=1).
- Abort: assert Rst=0 during the second EN cycle -> the next cycle has SSP_SSEL=0, SSP_En=0, busy=0; no rsp_valid ever appears for the aborted access.
- Zero gap: GAP_CYCLES=0 with requester 0 continuously valid -> rsp_valid and the next req_ready land in the same cycle; SSP_SSEL stays low for exactly one cycle (IDLE) between accesses.
